microseq_controller: RTL and testbench

- Parametrised microcoded control unit for the RV32I datapath, successor to the fixed two-cycle load/store sequencer.
- Decodes each instruction into a microcode address and looks up a 17-bit control word.
- Holds memory operations for a configurable number of wait cycles, or until a memory ready handshake (with timeout).
- Adds stall, illegal-instruction detection and a PC-advance strobe. Sits between instruction memory and datapath/regfile/data memory.

---
 rtl/microseq_pkg.sv | 63 ++++++
 rtl/microcode_rom.sv | 133 +++++++++++++
 rtl/microseq_controller.sv | 150 +++++++++++++++
 tb/tb_microseq_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// microseq_pkg: shared types for the microcoded RV32I control unit.
// Opcode groups, control word layout, ALU/branch encodings, FSM states.
package microseq_pkg;

  localparam logic [4:0] TYPE_R      = 5'b01100;
  localparam logic [4:0] TYPE_I_COMP = 5'b00100;
  localparam logic [4:0] TYPE_I_LOAD = 5'b00000;
  localparam logic [4:0] TYPE_I_JALR = 5'b11001;
  localparam logic [4:0] TYPE_S      = 5'b01000;
  localparam logic [4:0] TYPE_SB     = 5'b11000;
  localparam logic [4:0] LUI         = 5'b01101;
  localparam logic [4:0] AUIPC       = 5'b00101;
  localparam logic [4:0] JAL         = 5'b11011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alusel_t;

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_JUMP = 3'd1,
    BT_BGEU = 3'd2,
    BT_BEQ  = 3'd3,
    BT_BNE  = 3'd4,
    BT_BLT  = 3'd5,
    BT_BGE  = 3'd6,
    BT_BLTU = 3'd7
  } bt_t;

  localparam logic [1:0] LST_B = 2'd0;
  localparam logic [1:0] LST_H = 2'd1;
  localparam logic [1:0] LST_W = 2'd3;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC4 = 2'd2;

  typedef struct packed {
    logic       wen;
    alusel_t    alusel;
    logic       alub;
    logic       alua;
    logic       memw;
    logic       memr;
    logic [1:0] lst;
    logic       lu;
    logic [1:0] wsel;
    bt_t        bt;
  } ctrl_t;

  typedef enum logic {FETCH, HOLD} state_t;

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: address -> {valid, multi, control word}.
// Unmapped addresses return valid=0 and an all-zero control word.
module microcode_rom
  import microseq_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int CTRL_W = 17
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              multi,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  // Decode opcode group, then func3/bit30 within the group
  always_comb begin
    c     = '0;
    valid = 1'b1;
    multi = 1'b0;
    case (addr[ADDR_W-1 -: 5])
      TYPE_R, TYPE_I_COMP: begin
        c.wen  = 1'b1;
        c.alub = (addr[ADDR_W-1 -: 5] == TYPE_I_COMP);
        case (addr[3:0])
          4'b0000: c.alusel = ALU_ADD;
          4'b0010: c.alusel = ALU_SLL;
          4'b0100: c.alusel = ALU_SLT;
          4'b0110: c.alusel = ALU_SLTU;
          4'b1000: c.alusel = ALU_XOR;
          4'b1010: c.alusel = ALU_SRL;
          4'b1011: c.alusel = ALU_SRA;
          4'b1100: c.alusel = ALU_OR;
          4'b1110: c.alusel = ALU_AND;
          4'b0001: begin
            c.alusel = ALU_SUB;
            valid    = ~c.alub;
          end
          default: valid = 1'b0;
        endcase
      end
      TYPE_I_LOAD: begin
        c.wen  = 1'b1;
        c.alub = 1'b1;
        c.memr = 1'b1;
        c.wsel = WSEL_MEM;
        multi  = 1'b1;
        case (addr[3:0])
          4'b0000: c.lst = LST_B;
          4'b0010: c.lst = LST_H;
          4'b0100: c.lst = LST_W;
          4'b1000: begin
            c.lst = LST_B;
            c.lu  = 1'b1;
          end
          4'b1010: begin
            c.lst = LST_H;
            c.lu  = 1'b1;
          end
          default: valid = 1'b0;
        endcase
      end
      TYPE_S: begin
        c.alub = 1'b1;
        c.memw = 1'b1;
        multi  = 1'b1;
        case (addr[3:0])
          4'b0000: c.lst = LST_B;
          4'b0010: c.lst = LST_H;
          4'b0100: c.lst = LST_W;
          default: valid = 1'b0;
        endcase
      end
      TYPE_SB: begin
        c.alusel = ALU_SUB;
        case (addr[3:0])
          4'b0000: c.bt = BT_BEQ;
          4'b0010: c.bt = BT_BNE;
          4'b1000: begin
            c.bt     = BT_BLT;
            c.alusel = ALU_SLT;
          end
          4'b1010: begin
            c.bt     = BT_BGE;
            c.alusel = ALU_SLT;
          end
          4'b1100: begin
            c.bt     = BT_BLTU;
            c.alusel = ALU_SLTU;
          end
          4'b1110: begin
            c.bt     = BT_BGEU;
            c.alusel = ALU_SLTU;
          end
          default: valid = 1'b0;
        endcase
      end
      TYPE_I_JALR: begin
        c.wen  = 1'b1;
        c.alub = 1'b1;
        c.wsel = WSEL_PC4;
        c.bt   = BT_JUMP;
        valid  = (addr[3:0] == 4'b0000);
      end
      JAL: begin
        c.wen  = 1'b1;
        c.alua = 1'b1;
        c.alub = 1'b1;
        c.wsel = WSEL_PC4;
        c.bt   = BT_JUMP;
      end
      LUI: begin
        c.wen    = 1'b1;
        c.alub   = 1'b1;
        c.alusel = ALU_PASSB;
      end
      AUIPC: begin
        c.wen  = 1'b1;
        c.alua = 1'b1;
        c.alub = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    if (!valid) begin
      c     = '0;
      multi = 1'b0;
    end
  end

  assign ctrl = CTRL_W'(c);

endmodule

// File: rtl/microseq_controller.sv
// microseq_controller: microcoded RV32I control unit.
// Single-cycle dispatch; memory ops held for a wait count or mem_ready.
module microseq_controller
  import microseq_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int CTRL_W    = 17,
  parameter int USE_READY = 0,
  parameter int MEM_WAIT  = 1,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl_signals,
  output logic              busy,
  output logic              instr_done,
  output logic              pc_en,
  output logic              illegal,
  output logic              mem_error
);

  state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CTRL_W-1:0] held, held_n;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        op;
  logic [2:0]        f3;
  logic              use_f3, use_b30;
  logic              rom_valid, rom_multi;
  logic [CTRL_W-1:0] rom_ctrl;
  logic              hold_req;
  logic [CTRL_W-1:0] ctrl_c;
  logic              busy_c, done_c, ill_c, merr_c;
  logic              unused_bits;

  assign op = instruction[6:2];
  assign f3 = instruction[14:12];
  assign unused_bits = ^{instruction[31], instruction[29:15],
                         instruction[11:7], instruction[1:0]};

  // Microcode address from opcode, func3 and bit30
  always_comb begin
    use_f3 = (op == TYPE_R) || (op == TYPE_I_COMP) ||
             (op == TYPE_I_LOAD) || (op == TYPE_I_JALR) ||
             (op == TYPE_S) || (op == TYPE_SB);
    use_b30 = (op == TYPE_R) ||
              ((op == TYPE_I_COMP) && (f3 == 3'b101));
    addr = ADDR_W'({op, use_f3 ? f3 : 3'b000,
                    use_b30 ? instruction[30] : 1'b0});
  end

  microcode_rom #(
    .ADDR_W(ADDR_W),
    .CTRL_W(CTRL_W)
  ) u_rom (
    .addr (addr),
    .valid(rom_valid),
    .multi(rom_multi),
    .ctrl (rom_ctrl)
  );

  assign hold_req = (USE_READY != 0) ? ~mem_ready : (MEM_WAIT != 0);

  // Next state, counter, held word and combinational outputs
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    held_n  = held;
    ctrl_c  = '0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    ill_c   = 1'b0;
    merr_c  = 1'b0;
    unique case (state)
      FETCH: begin
        if (instr_valid) begin
          if (!rom_valid) begin
            ill_c  = 1'b1;
            done_c = 1'b1;
          end else begin
            ctrl_c = rom_ctrl;
            if (rom_multi) begin
              held_n = rom_ctrl;
              if (hold_req) begin
                state_n = HOLD;
                cnt_n   = CNT_W'(1);
              end else begin
                done_c = 1'b1;
              end
            end else begin
              done_c = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        busy_c = 1'b1;
        ctrl_c = held;
        if (USE_READY == 0) begin
          if (cnt == CNT_W'(MEM_WAIT)) begin
            done_c  = 1'b1;
            state_n = FETCH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (mem_ready) begin
          done_c  = 1'b1;
          state_n = FETCH;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(TIMEOUT) && !stall) begin
          ctrl_c  = '0;
          merr_c  = 1'b1;
          done_c  = 1'b1;
          state_n = FETCH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Sequencer registers, frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
      held  <= '0;
    end else if (!stall) begin
      state <= state_n;
      cnt   <= cnt_n;
      held  <= held_n;
    end
  end

  assign ctrl_signals = rst ? '0 : ctrl_c;
  assign busy         = ~rst & busy_c;
  assign instr_done   = ~rst & done_c;
  assign pc_en        = ~rst & done_c & ~stall;
  assign illegal      = ~rst & ill_c;
  assign mem_error    = ~rst & merr_c;

endmodule

// File: tb/tb_microseq_controller.sv
// tb_microseq_controller: directed checks of fixed-wait and ready modes.
// Two instances share stimulus; each has its own instr_valid.
module tb_microseq_controller;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0000A283;
  localparam logic [31:0] I_SW  = 32'h0050A223;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        vf, vr, stall, mem_ready;

  logic [16:0] ctrl_f, ctrl_r;
  logic        busy_f, done_f, pc_f, ill_f, merr_f;
  logic        busy_r, done_r, pc_r, ill_r, merr_r;

  int total = 0;
  int bad   = 0;
  int dones;

  always #5 clk = ~clk;

  microseq_controller #(
    .USE_READY(0),
    .MEM_WAIT (2)
  ) dut_f (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (vf),
    .stall       (stall),
    .mem_ready   (mem_ready),
    .ctrl_signals(ctrl_f),
    .busy        (busy_f),
    .instr_done  (done_f),
    .pc_en       (pc_f),
    .illegal     (ill_f),
    .mem_error   (merr_f)
  );

  microseq_controller #(
    .USE_READY(1),
    .TIMEOUT  (15)
  ) dut_r (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (vr),
    .stall       (stall),
    .mem_ready   (mem_ready),
    .ctrl_signals(ctrl_r),
    .busy        (busy_r),
    .instr_done  (done_r),
    .pc_en       (pc_r),
    .illegal     (ill_r),
    .mem_error   (merr_r)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    instruction = I_ADD;
    vf          = 1'b1;
    vr          = 1'b1;
    stall       = 1'b0;
    mem_ready   = 1'b1;

    sample;
    check("rst_ctrl_f", ctrl_f, 0);
    check("rst_done_f", done_f, 0);
    check("rst_ctrl_r", ctrl_r, 0);
    check("rst_pc_r", pc_r, 0);

    next_cyc;
    rst = 1'b0;
    sample;
    check("add_ctrl", ctrl_f, 17'h10000);
    check("add_done", done_f, 1);
    check("add_pc", pc_f, 1);
    check("add_busy", busy_f, 0);
    check("add_ctrl_r", ctrl_r, 17'h10000);

    next_cyc;
    instruction = I_BEQ;
    sample;
    check("beq_ctrl", ctrl_f, 17'h01003);
    check("beq_done", done_f, 1);
    check("beq_ill", ill_f, 0);

    next_cyc;
    instruction = I_BAD;
    sample;
    check("bad_ctrl", ctrl_f, 0);
    check("bad_ill", ill_f, 1);
    check("bad_done", done_f, 1);
    check("bad_pc", pc_f, 1);

    next_cyc;
    vf = 1'b0;
    vr = 1'b0;
    sample;
    check("idle_done", done_f, 0);
    check("idle_ctrl", ctrl_f, 0);
    check("idle_ill", ill_f, 0);

    next_cyc;
    instruction = I_LW;
    vf = 1'b1;
    sample;
    check("lw1_ctrl", ctrl_f, 17'h109C8);
    check("lw1_busy", busy_f, 0);
    check("lw1_done", done_f, 0);
    next_cyc;
    sample;
    check("lw2_ctrl", ctrl_f, 17'h109C8);
    check("lw2_busy", busy_f, 1);
    check("lw2_done", done_f, 0);
    next_cyc;
    sample;
    check("lw3_ctrl", ctrl_f, 17'h109C8);
    check("lw3_busy", busy_f, 1);
    check("lw3_done", done_f, 1);
    check("lw3_pc", pc_f, 1);
    next_cyc;
    vf = 1'b0;
    sample;
    check("lw_after_busy", busy_f, 0);
    check("lw_after_ctrl", ctrl_f, 0);

    next_cyc;
    instruction = I_SW;
    vr = 1'b1;
    mem_ready = 1'b0;
    sample;
    check("sw0_ctrl", ctrl_r, 17'h00AC0);
    check("sw0_busy", busy_r, 0);
    check("sw0_done", done_r, 0);
    for (int i = 1; i <= 4; i++) begin
      next_cyc;
      mem_ready = (i == 4);
      sample;
      check("sw_hold_busy", busy_r, 1);
      check("sw_hold_ctrl", ctrl_r, 17'h00AC0);
      check("sw_hold_done", done_r, (i == 4));
      check("sw_hold_merr", merr_r, 0);
    end
    next_cyc;
    vr = 1'b0;
    mem_ready = 1'b0;
    sample;
    check("sw_after_busy", busy_r, 0);

    next_cyc;
    vr = 1'b1;
    sample;
    check("to0_busy", busy_r, 0);
    for (int i = 1; i <= 15; i++) begin
      next_cyc;
      sample;
      check("to_merr", merr_r, (i == 15));
      check("to_done", done_r, (i == 15));
      check("to_ctrl", ctrl_r, (i == 15) ? 0 : 17'h00AC0);
    end
    next_cyc;
    vr = 1'b0;
    sample;
    check("to_after_busy", busy_r, 0);
    check("to_after_merr", merr_r, 0);

    next_cyc;
    vr = 1'b1;
    sample;
    for (int i = 1; i <= 15; i++) begin
      next_cyc;
      mem_ready = (i == 15);
      sample;
      if (i == 15) begin
        check("race_done", done_r, 1);
        check("race_merr", merr_r, 0);
        check("race_ctrl", ctrl_r, 17'h00AC0);
      end
    end
    next_cyc;
    mem_ready = 1'b1;
    sample;
    check("rdy_now_done", done_r, 1);
    check("rdy_now_busy", busy_r, 0);
    check("rdy_now_ctrl", ctrl_r, 17'h00AC0);
    next_cyc;
    vr = 1'b0;
    mem_ready = 1'b0;
    sample;
    check("rdy_now_after", busy_r, 0);

    next_cyc;
    instruction = I_LW;
    vf = 1'b1;
    dones = 0;
    sample;
    if (done_f) dones++;
    for (int c = 2; c <= 6; c++) begin
      next_cyc;
      stall = (c >= 2 && c <= 4);
      sample;
      if (done_f) dones++;
      check("st_busy", busy_f, 1);
      if (c <= 4) check("st_pc", pc_f, 0);
      if (c == 6) check("st_done6", done_f, 1);
    end
    check("st_done_count", dones, 1);
    next_cyc;
    vf = 1'b0;
    stall = 1'b0;
    sample;
    check("st_after_busy", busy_f, 0);

    next_cyc;
    instruction = I_LW;
    vf = 1'b1;
    sample;
    next_cyc;
    sample;
    check("rh_busy", busy_f, 1);
    #1 rst = 1'b1;
    #1;
    check("rh_ctrl", ctrl_f, 0);
    check("rh_busy0", busy_f, 0);
    check("rh_done", done_f, 0);
    next_cyc;
    rst = 1'b0;
    instruction = I_ADD;
    sample;
    check("rh_add_ctrl", ctrl_f, 17'h10000);
    check("rh_add_done", done_f, 1);
    check("rh_add_busy", busy_f, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
